// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI-Stream frame stimulus generator for link bring-up/soak (user_clk_out domain).
// Latency: first beat gap+2 cycles after enable rises; gap idle cycles between frames (0 = back-to-back).
// Backpressure: honours m_axis_tready; tvalid/tdata/tlast hold while stalled, no beat lost or repeated.
//
// Ports: clk/rst_n (async active-low); enable (level run request); frame_len (beats, 0 -> 1),
//        gap (idle cycles), mode (0 CONST, 1 INCR, 2 LFSR, 3 FRAME_ID), seed; m_axis_* master
//        stream; busy (frame in flight); frame_count (completed frames, wraps).
// Build option: define FRAME_GEN_CHECKSUM_EN to append one XOR-checksum beat to every frame.
module axis_frame_gen #(
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 8,
    parameter int GAP_W       = 8,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [LEN_W-1:0]       frame_len,
    input  logic [GAP_W-1:0]       gap,
    input  logic [1:0]             mode,
    input  logic [DATA_W-1:0]      seed,
    output logic                   m_axis_tvalid,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam logic [1:0]  MODE_CONST    = 2'd0;
    localparam logic [1:0]  MODE_INCR     = 2'd1;
    localparam logic [1:0]  MODE_LFSR     = 2'd2;
    localparam logic [1:0]  MODE_FRAME_ID = 2'd3;
    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;

    typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_SEND} state_t;

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [LEN_W-1:0]   beat_idx;
    logic [LEN_W-1:0]   lat_len;
    logic [1:0]         lat_mode;
    logic [DATA_W-1:0]  lat_seed;
    logic [31:0]        lfsr;
    logic               first_frame;
`ifdef FRAME_GEN_CHECKSUM_EN
    logic [DATA_W-1:0]  csum;
    logic               last_data;
`endif

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] beat_data(input logic [1:0]             m,
                                                    input logic [DATA_W-1:0]      sd,
                                                    input logic [LEN_W-1:0]       idx,
                                                    input logic [31:0]            lf,
                                                    input logic [FRAME_CNT_W-1:0] fc);
        logic [DATA_W-1:0] d;
        case (m)
            MODE_CONST:    d = sd;
            MODE_INCR:     d = sd + DATA_W'(idx);
            MODE_LFSR:     d = DATA_W'(lf);
            MODE_FRAME_ID: d = (idx == '0) ? DATA_W'(fc) : sd + DATA_W'(idx);
            default:       d = sd;
        endcase
        return d;
    endfunction

    logic                   hs;
    logic                   data_hs;
    logic                   do_start;
    logic [LEN_W-1:0]       nxt_idx;
    logic [LEN_W-1:0]       start_len;
    logic [31:0]            lfsr_adv;
    logic [31:0]            seed32;
    logic [31:0]            start_lfsr;
    logic [FRAME_CNT_W-1:0] start_fc;
    logic [DATA_W-1:0]      start_dat;
    logic [DATA_W-1:0]      nxt_dat;

    always_comb begin
        hs        = m_axis_tvalid & m_axis_tready;
        nxt_idx   = beat_idx + 1'b1;
`ifdef FRAME_GEN_CHECKSUM_EN
        last_data = (beat_idx == lat_len - 1'b1);
        // The checksum beat sits at index lat_len and does not move the LFSR.
        data_hs   = hs & (beat_idx != lat_len);
`else
        data_hs   = hs;
`endif
        lfsr_adv  = data_hs ? lfsr_step(lfsr) : lfsr;
        seed32    = 32'(seed);
        start_len = (frame_len == '0) ? LEN_W'(1) : frame_len;
        // Only the first frame after enable reseeds; later frames continue the sequence.
        start_lfsr = (mode == MODE_LFSR && first_frame) ?
                     ((seed32 == '0) ? 32'd1 : seed32) : lfsr_adv;
        // A back-to-back start coincides with the previous frame's completion.
        start_fc  = hs ? frame_count + 1'b1 : frame_count;
        start_dat = beat_data(mode, seed, '0, start_lfsr, start_fc);
        nxt_dat   = beat_data(lat_mode, lat_seed, nxt_idx, lfsr_adv, frame_count);
        do_start  = enable && ((state == ST_GAP && gap_cnt >= gap) ||
                               (state == ST_SEND && hs && m_axis_tlast && gap == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            gap_cnt       <= '0;
            beat_idx      <= '0;
            lat_len       <= '0;
            lat_mode      <= MODE_CONST;
            lat_seed      <= '0;
            lfsr          <= 32'd1;
            first_frame   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            frame_count   <= '0;
`ifdef FRAME_GEN_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            if (hs && m_axis_tlast) begin
                frame_count <= frame_count + 1'b1;
            end
            if (data_hs) begin
                lfsr <= lfsr_adv;
            end
            if (do_start) begin
                state         <= ST_SEND;
                lat_len       <= start_len;
                lat_mode      <= mode;
                lat_seed      <= seed;
                lfsr          <= start_lfsr;
                first_frame   <= 1'b0;
                beat_idx      <= '0;
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= start_dat;
                busy          <= 1'b1;
`ifdef FRAME_GEN_CHECKSUM_EN
                m_axis_tlast  <= 1'b0;
                csum          <= '0;
`else
                m_axis_tlast  <= (start_len == LEN_W'(1));
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (enable) begin
                            state       <= ST_GAP;
                            gap_cnt     <= '0;
                            first_frame <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (!enable) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (hs) begin
                            if (m_axis_tlast) begin
                                // Counter restarts at 1 so exactly 'gap' idle cycles follow.
                                state         <= enable ? ST_GAP : ST_IDLE;
                                gap_cnt       <= GAP_W'(1);
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                busy          <= 1'b0;
                            end
`ifdef FRAME_GEN_CHECKSUM_EN
                            else if (last_data) begin
                                beat_idx     <= nxt_idx;
                                m_axis_tdata <= csum ^ m_axis_tdata;
                                m_axis_tlast <= 1'b1;
                            end else begin
                                beat_idx     <= nxt_idx;
                                m_axis_tdata <= nxt_dat;
                                csum         <= csum ^ m_axis_tdata;
                            end
`else
                            else begin
                                beat_idx     <= nxt_idx;
                                m_axis_tdata <= nxt_dat;
                                m_axis_tlast <= (nxt_idx == lat_len - 1'b1);
                            end
`endif
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb_axis_frame_gen: directed stimulus against a queue-based beat model of axis_frame_gen.
// Latency: n/a (bench); outputs sampled on the falling edge, inputs driven 1 ns after rising edge.
// Backpressure: optional 50% random tready; stall stability checked every stalled cycle.
module tb_axis_frame_gen;

    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int GW  = 8;
    localparam int CW  = 16;
    localparam int TMO = 5000;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          enable    = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [GW-1:0] gap       = '0;
    logic [1:0]    mode      = 2'd0;
    logic [DW-1:0] seed      = '0;
    logic          tready    = 1'b1;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          busy;
    logic [CW-1:0] frame_count;

    axis_frame_gen #(.DATA_W(DW), .LEN_W(LW), .GAP_W(GW), .FRAME_CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .frame_len     (frame_len),
        .gap           (gap),
        .mode          (mode),
        .seed          (seed),
        .m_axis_tvalid (tvalid),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast),
        .m_axis_tready (tready),
        .busy          (busy),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no progress after %0d cycles", name, TMO);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] seen[$];
    logic [31:0]   m_lfsr = 32'd1;
    logic [CW-1:0] m_fc   = '0;

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
        return r;
    endfunction

    task automatic push_frame(input logic [1:0] md, input logic [DW-1:0] sd, input int len);
        int            n;
        logic [DW-1:0] x;
        logic [DW-1:0] d;
        beat_t         b;
        n = (len == 0) ? 1 : len;
        x = '0;
        for (int i = 0; i < n; i++) begin
            case (md)
                2'd0:    d = sd;
                2'd1:    d = sd + DW'(i);
                2'd2:    begin d = m_lfsr; m_lfsr = ref_step(m_lfsr); end
                default: d = (i == 0) ? DW'(m_fc) : sd + DW'(i);
            endcase
            x = x ^ d;
            b.d = d;
`ifdef FRAME_GEN_CHECKSUM_EN
            b.l = 1'b0;
`else
            b.l = (i == n - 1);
`endif
            exp_q.push_back(b);
        end
`ifdef FRAME_GEN_CHECKSUM_EN
        b.d = x;
        b.l = 1'b1;
        exp_q.push_back(b);
`endif
        m_fc = m_fc + 1'b1;
    endtask

    // ---------------- ready driver ----------------
    bit rand_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // ---------------- compare process ----------------
    logic          prev_vld  = 1'b0;
    logic          prev_rdy  = 1'b0;
    logic          prev_last = 1'b0;
    logic [DW-1:0] prev_dat  = '0;
    bit            gap_chk   = 1'b0;
    int            exp_gap   = 0;
    bit            measuring = 1'b0;
    int            idle_cnt  = 0;

    always @(negedge clk) begin : cmp
        beat_t e;
        if (!rst_n) begin
            prev_vld  = 1'b0;
            measuring = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                check("stall_tvalid", 64'(tvalid), 64'(1'b1));
                check("stall_tdata", 64'(tdata), 64'(prev_dat));
                check("stall_tlast", 64'(tlast), 64'(prev_last));
            end
            check("busy_vs_frame", 64'(busy), 64'(tvalid));
            if (!gap_chk) measuring = 1'b0;
            if (measuring && tvalid) begin
                check("idle_gap", 64'(idle_cnt), 64'(exp_gap));
                measuring = 1'b0;
            end else if (measuring) begin
                idle_cnt++;
            end
            if (tvalid && tready) begin
                seen.push_back(tdata);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_beat: got 0x%0h, expected no beat", tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_tdata", 64'(tdata), 64'(e.d));
                    check("beat_tlast", 64'(tlast), 64'(e.l));
                end
                if (tlast) begin
                    measuring = 1'b1;
                    idle_cnt  = 0;
                end
            end
            prev_vld  = tvalid;
            prev_rdy  = tready;
            prev_dat  = tdata;
            prev_last = tlast;
        end
    end

    // ---------------- scenario helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frames(input logic [1:0] md, input logic [DW-1:0] sd, input int len,
                              input int gp, input int nfr, input int drop_left, input bit chk_gap);
        int total;
        int t;
        mode      = md;
        seed      = sd;
        frame_len = LW'(len);
        gap       = GW'(gp);
        if (md == 2'd2) m_lfsr = (sd == '0) ? 32'd1 : sd;
        for (int f = 0; f < nfr; f++) push_frame(md, sd, len);
        total   = exp_q.size();
        exp_gap = gp;
        gap_chk = chk_gap;
        enable  = 1'b1;
        t = 0;
        while (!(exp_q.size() <= drop_left && exp_q.size() < total) && t < TMO) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= TMO) timeout("run_progress");
        @(posedge clk);
        #1;
        enable = 1'b0;
        t = 0;
        while ((exp_q.size() != 0 || tvalid) && t < TMO) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= TMO) timeout("run_drain");
        wait_cycles(3);
        gap_chk = 1'b0;
        check("end_frame_count", 64'(frame_count), 64'(m_fc));
        check("end_tvalid", 64'(tvalid), 64'(1'b0));
        check("end_busy", 64'(busy), 64'(1'b0));
        wait_cycles(2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        #12;
        check("rst_tvalid", 64'(tvalid), 64'(1'b0));
        check("rst_tlast", 64'(tlast), 64'(1'b0));
        check("rst_tdata", 64'(tdata), 64'h0);
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_frame_count", 64'(frame_count), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(2);

        // Model pins: hand-stepped LFSR states from state 1.
        check("model_lfsr_1", 64'(ref_step(32'd1)), 64'h8020_0003);
        check("model_lfsr_2", 64'(ref_step(ref_step(32'd1))), 64'hC030_0002);

        // CONST, long gap.
        base = seen.size();
        run_frames(2'd0, 32'd5, 2, 255, 3, 1, 1'b1);
        check("const_b0", 64'(seen[base]), 64'd5);
        check("const_b1", 64'(seen[base + 1]), 64'd5);
        check("const_fc", 64'(frame_count), 64'd3);

        // INCR wrap, back-to-back.
        base = seen.size();
        run_frames(2'd1, 32'hFFFF_FFFE, 4, 0, 3, 1, 1'b1);
        check("incr_b0", 64'(seen[base]), 64'hFFFF_FFFE);
        check("incr_b1", 64'(seen[base + 1]), 64'hFFFF_FFFF);
        check("incr_b2", 64'(seen[base + 2]), 64'h0);
        check("incr_b3", 64'(seen[base + 3]), 64'h1);

        // INCR under random backpressure.
        rand_rdy = 1'b1;
        run_frames(2'd1, 32'h0000_1000, 8, 2, 6, 1, 1'b1);
        rand_rdy = 1'b0;
        wait_cycles(2);

        // LFSR seed 0, 1000 beats.
        base = seen.size();
        run_frames(2'd2, 32'd0, 8, 0, 125, 1, 1'b1);
        check("lfsr_b0", 64'(seen[base]), 64'h1);
        check("lfsr_b1", 64'(seen[base + 1]), 64'h8020_0003);
        check("lfsr_b2", 64'(seen[base + 2]), 64'hC030_0002);

        // FRAME_ID after 137 completed frames.
        base = seen.size();
        run_frames(2'd3, 32'h50, 3, 1, 2, 1, 1'b1);
        check("fid_b0", 64'(seen[base]), 64'd137);
        check("fid_b1", 64'(seen[base + 1]), 64'h51);
        check("fid_b2", 64'(seen[base + 2]), 64'h52);

        // enable dropped while beat 3 of 8 is presented.
        run_frames(2'd1, 32'd100, 8, 3, 1, 5, 1'b0);
        check("drop_fc", 64'(frame_count), 64'd140);

        // frame_len 0 behaves as 1.
        run_frames(2'd0, 32'd7, 0, 0, 2, 1, 1'b1);

        // Reset in the middle of a frame.
        mode      = 2'd1;
        seed      = 32'd0;
        frame_len = LW'(8);
        gap       = '0;
        push_frame(2'd1, 32'd0, 8);
        enable = 1'b1;
        begin
            int t;
            t = 0;
            while (exp_q.size() > 5 && t < TMO) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (t >= TMO) timeout("reset_progress");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        m_fc   = '0;
        m_lfsr = 32'd1;
        #1;
        check("mid_rst_tvalid", 64'(tvalid), 64'(1'b0));
        check("mid_rst_busy", 64'(busy), 64'(1'b0));
        check("mid_rst_fc", 64'(frame_count), 64'h0);
        enable = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        run_frames(2'd0, 32'd9, 2, 0, 1, 1, 1'b0);
        check("post_rst_fc", 64'(frame_count), 64'd1);

`ifdef FRAME_GEN_CHECKSUM_EN
        base = seen.size();
        run_frames(2'd0, 32'hA5, 3, 0, 1, 1, 1'b0);
        check("csum_beat", 64'(seen[base + 3]), 64'hA5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
